viterbi_err_channel: RTL and testbench

//  Parametrised error-injecting channel between convolutional encoder and Viterbi decoder.

---
 rtl/viterbi_chan_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 33 +++
 rtl/viterbi_err_channel.sv | 189 ++++++++++++++++++
 tb/tb_viterbi_err_channel.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_chan_pkg.sv
// Shared types, constants and helpers for the Viterbi error-injection channel.
// popcount covers masks up to 32 bits wide.
package viterbi_chan_pkg;

   typedef enum logic [1:0] {
      MODE_OFF      = 2'd0,
      MODE_PERIODIC = 2'd1,
      MODE_BURST    = 2'd2,
      MODE_RANDOM   = 2'd3
   } chan_mode_e;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_GAP   = 2'd1,
      S_BURST = 2'd2,
      S_RAND  = 2'd3
   } chan_state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   // State the FSM (re)enters whenever the selected mode changes.
   function automatic chan_state_e entry_state(input chan_mode_e m);
      chan_state_e s;
      case (m)
         MODE_PERIODIC, MODE_BURST: s = S_GAP;
         MODE_RANDOM:               s = S_RAND;
         default:                   s = S_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle while en_i is high.
module lfsr16
   import viterbi_chan_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/viterbi_err_channel.sv
// Error-injecting channel between a convolutional encoder and a Viterbi decoder:
// one register stage that XORs cfg_mask_i onto periodically, burst- or LFSR-selected symbols.
module viterbi_err_channel
   import viterbi_chan_pkg::*;
#(
   parameter int unsigned W      = 2,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned STAT_W = 32,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cfg_mode_i,
   input  logic [CNT_W-1:0]  cfg_period_i,
   input  logic [3:0]        cfg_burst_i,
   input  logic [7:0]        cfg_thresh_i,
   input  logic [W-1:0]      cfg_mask_i,
   input  logic              clr_stats_i,
   input  logic              valid_i,
   input  logic [W-1:0]      sym_i,
   output logic              valid_o,
   output logic [W-1:0]      sym_o,
   output logic              err_o,
   output logic [STAT_W-1:0] sym_ct_o,
   output logic [STAT_W-1:0] bit_err_ct_o,
   output chan_state_e       dbg_state_o,
   output logic [15:0]       dbg_lfsr_o
);

   // Handshake: valid_i qualifies sym_i for exactly one cycle and there is no backpressure;
   // valid_o/sym_o/err_o follow one cycle later, and sym_o/err_o hold while valid_o is low.

   chan_state_e       state_q, state_d, cur_state;
   chan_mode_e        mode_q, mode_d, mode_in;
   logic [CNT_W-1:0]  phase_q, phase_d, cur_phase;
   logic [3:0]        burst_left_q, burst_left_d;
   logic [3:0]        burst_eff;
   logic [CNT_W-1:0]  burst_ext;
   logic              mode_chg;
   logic              hit;
   logic              lfsr_en;
   logic [15:0]       lfsr_state;

   logic              valid_o_q, valid_o_d;
   logic [W-1:0]      sym_o_q, sym_o_d;
   logic              err_o_q, err_o_d;
   logic [STAT_W-1:0] sym_ct_q, sym_ct_d;
   logic [STAT_W-1:0] bit_err_ct_q, bit_err_ct_d;
   logic [STAT_W-1:0] flips;
   logic [STAT_W:0]   sym_sum, bit_sum;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (lfsr_en),
      .state_o (lfsr_state)
   );

   // Next-state logic; a mode change is applied to the very symbol that carries it.
   always_comb begin
      mode_in   = chan_mode_e'(cfg_mode_i);
      mode_chg  = (mode_in != mode_q);
      burst_eff = (cfg_burst_i == 4'd0) ? 4'd1 : cfg_burst_i;
      burst_ext = CNT_W'(burst_eff);
      cur_state = mode_chg ? entry_state(mode_in) : state_q;
      cur_phase = mode_chg ? '0 : phase_q;

      state_d      = state_q;
      mode_d       = mode_q;
      phase_d      = phase_q;
      burst_left_d = burst_left_q;
      hit          = 1'b0;
      lfsr_en      = 1'b0;

      if (valid_i) begin
         mode_d  = mode_in;
         state_d = cur_state;
         phase_d = cur_phase;
         if (mode_chg) begin
            burst_left_d = '0;
         end
         case (cur_state)
            S_OFF: begin
               phase_d = '0;
            end
            S_GAP: begin
               if (cfg_period_i == '0) begin
                  phase_d = '0;
               end else if (mode_in == MODE_BURST && burst_ext >= cfg_period_i) begin
                  hit     = 1'b1;
                  phase_d = '0;
               end else if (cur_phase >= cfg_period_i - CNT_W'(1)) begin
                  hit     = 1'b1;
                  phase_d = '0;
                  if (mode_in == MODE_BURST && burst_eff > 4'd1) begin
                     state_d      = S_BURST;
                     burst_left_d = burst_eff - 4'd1;
                  end
               end else begin
                  phase_d = cur_phase + CNT_W'(1);
               end
            end
            S_BURST: begin
               // Phase keeps counting through the burst so the period stays aligned.
               hit     = 1'b1;
               phase_d = cur_phase + CNT_W'(1);
               if (burst_left_q <= 4'd1) begin
                  state_d      = S_GAP;
                  burst_left_d = '0;
               end else begin
                  burst_left_d = burst_left_q - 4'd1;
               end
            end
            S_RAND: begin
               lfsr_en = 1'b1;
               hit     = (lfsr_state[7:0] < cfg_thresh_i);
               phase_d = '0;
            end
            default: begin
               state_d = S_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_OFF;
         mode_q       <= MODE_OFF;
         phase_q      <= '0;
         burst_left_q <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         phase_q      <= phase_d;
         burst_left_q <= burst_left_d;
      end
   end

   // Output stage and saturating statistics; a clear beats a same-cycle count.
   always_comb begin
      valid_o_d    = valid_i;
      sym_o_d      = sym_o_q;
      err_o_d      = err_o_q;
      sym_ct_d     = sym_ct_q;
      bit_err_ct_d = bit_err_ct_q;
      flips        = hit ? STAT_W'(popcount(32'(cfg_mask_i))) : '0;
      sym_sum      = {1'b0, sym_ct_q} + (STAT_W+1)'(1);
      bit_sum      = {1'b0, bit_err_ct_q} + {1'b0, flips};

      if (valid_i) begin
         sym_o_d = sym_i ^ (hit ? cfg_mask_i : '0);
         err_o_d = hit;
      end

      if (clr_stats_i) begin
         sym_ct_d     = '0;
         bit_err_ct_d = '0;
      end else if (valid_i) begin
         sym_ct_d     = sym_sum[STAT_W] ? '1 : sym_sum[STAT_W-1:0];
         bit_err_ct_d = bit_sum[STAT_W] ? '1 : bit_sum[STAT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o_q    <= 1'b0;
         sym_o_q      <= '0;
         err_o_q      <= 1'b0;
         sym_ct_q     <= '0;
         bit_err_ct_q <= '0;
      end else begin
         valid_o_q    <= valid_o_d;
         sym_o_q      <= sym_o_d;
         err_o_q      <= err_o_d;
         sym_ct_q     <= sym_ct_d;
         bit_err_ct_q <= bit_err_ct_d;
      end
   end

   assign valid_o      = valid_o_q;
   assign sym_o        = sym_o_q;
   assign err_o        = err_o_q;
   assign sym_ct_o     = sym_ct_q;
   assign bit_err_ct_o = bit_err_ct_q;
   assign dbg_state_o  = state_q;
   assign dbg_lfsr_o   = lfsr_state;

endmodule

// File: tb/tb_viterbi_err_channel.sv
// Scoreboard bench for viterbi_err_channel: directed streams push expected {sym, err},
// a negedge monitor pops and compares whenever valid_o is high.
module tb_viterbi_err_channel;
   import viterbi_chan_pkg::*;

   localparam int W  = 2;
   localparam int EW = W + 1;

   logic              clk;
   logic              rst;
   logic [1:0]        cfg_mode_i;
   logic [15:0]       cfg_period_i;
   logic [3:0]        cfg_burst_i;
   logic [7:0]        cfg_thresh_i;
   logic [W-1:0]      cfg_mask_i;
   logic              clr_stats_i;
   logic              valid_i;
   logic [W-1:0]      sym_i;
   logic              valid_o;
   logic [W-1:0]      sym_o;
   logic              err_o;
   logic [31:0]       sym_ct_o;
   logic [31:0]       bit_err_ct_o;
   chan_state_e       dbg_state_o;
   logic [15:0]       dbg_lfsr_o;

   logic [EW-1:0]     exp_q[$];
   logic [EW-1:0]     mon_exp;
   logic [15:0]       lfsr_m;
   int                n_vec = 0;
   int                n_err = 0;

   viterbi_err_channel #(
      .W(W), .CNT_W(16), .STAT_W(32), .SEED(16'hACE1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_mode_i   (cfg_mode_i),
      .cfg_period_i (cfg_period_i),
      .cfg_burst_i  (cfg_burst_i),
      .cfg_thresh_i (cfg_thresh_i),
      .cfg_mask_i   (cfg_mask_i),
      .clr_stats_i  (clr_stats_i),
      .valid_i      (valid_i),
      .sym_i        (sym_i),
      .valid_o      (valid_o),
      .sym_o        (sym_o),
      .err_o        (err_o),
      .sym_ct_o     (sym_ct_o),
      .bit_err_ct_o (bit_err_ct_o),
      .dbg_state_o  (dbg_state_o),
      .dbg_lfsr_o   (dbg_lfsr_o)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog: time limit reached, got still running, required finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Drivers
   task automatic send(input logic [W-1:0] s, input logic h);
      @(negedge clk);
      valid_i     = 1'b1;
      sym_i       = s;
      clr_stats_i = 1'b0;
      exp_q.push_back({s ^ (h ? cfg_mask_i : 2'b00), h});
   endtask

   task automatic idle();
      @(negedge clk);
      valid_i     = 1'b0;
      clr_stats_i = 1'b0;
   endtask

   task automatic check_stats(input int sc, input int bc);
      idle();
      check("sym_ct", 64'(sym_ct_o), 64'(sc));
      check("bit_err_ct", 64'(bit_err_ct_o), 64'(bc));
   endtask

   task automatic check_hold(input logic [W-1:0] s, input logic e);
      @(negedge clk);
      check("idle hold valid/sym/err", 64'({valid_o, sym_o, err_o}), 64'({1'b0, s, e}));
   endtask

   task automatic do_reset();
      valid_i     = 1'b0;
      clr_stats_i = 1'b0;
      rst         = 1'b0;
      #1;
      check("reset valid/sym/err", 64'({valid_o, sym_o, err_o}), 64'd0);
      check("reset counters", {sym_ct_o, bit_err_ct_o}, 64'd0);
      check("reset state", 64'(dbg_state_o), 64'(S_OFF));
      check("reset lfsr", 64'(dbg_lfsr_o), 64'h ACE1);
      exp_q.delete();
      lfsr_m = 16'hACE1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst && valid_o) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got unexpected sym=%0h err=%0b, expected no output", sym_o, err_o);
         end else begin
            mon_exp = exp_q.pop_front();
            check("scoreboard sym/err", 64'({sym_o, err_o}), 64'(mon_exp));
         end
      end
   end

   // Stimulus
   initial begin
      logic h;
      int   hits;
      rst          = 1'b1;
      valid_i      = 1'b0;
      sym_i        = '0;
      clr_stats_i  = 1'b0;
      cfg_mode_i   = 2'd0;
      cfg_period_i = 16'd16;
      cfg_burst_i  = 4'd1;
      cfg_thresh_i = 8'd0;
      cfg_mask_i   = 2'b01;
      lfsr_m       = 16'hACE1;
      #3;
      do_reset();

      // OFF: transparent, one cycle late
      for (int n = 1; n <= 100; n++) send(2'(n), 1'b0);
      check_stats(100, 0);

      // PERIODIC, period 16: every 16th symbol
      do_reset();
      cfg_mode_i = 2'd1; cfg_period_i = 16'd16; cfg_mask_i = 2'b01;
      for (int n = 1; n <= 256; n++) send(2'(n * 3), (n % 16) == 0);
      check_stats(256, 16);

      // BURST, period 10, burst 2: pairs 10-11, 20-21, 30-31, 40-41
      do_reset();
      cfg_mode_i = 2'd2; cfg_period_i = 16'd10; cfg_burst_i = 4'd2; cfg_mask_i = 2'b11;
      for (int n = 1; n <= 41; n++) begin
         h = ((n % 10) == 0) || ((n % 10) == 1 && n > 10);
         send(2'(n), h);
      end
      check_stats(41, 16);

      // PERIODIC period 3 with idle gaps: every 3rd valid, outputs hold when idle
      do_reset();
      cfg_mode_i = 2'd1; cfg_period_i = 16'd3; cfg_mask_i = 2'b10;
      for (int n = 1; n <= 9; n++) begin
         send(2'(n), (n % 3) == 0);
         idle();
         if (n == 3) check_hold(2'(n) ^ cfg_mask_i, 1'b1);
      end
      check_stats(9, 3);

      // RANDOM: thresh 0 never hits, thresh 255 follows the golden LFSR
      do_reset();
      cfg_mode_i = 2'd3; cfg_thresh_i = 8'd0; cfg_mask_i = 2'b01;
      hits = 0;
      for (int n = 1; n <= 1000; n++) begin
         h = (lfsr_m[7:0] < cfg_thresh_i);
         lfsr_m = lfsr_step(lfsr_m);
         send(2'(n), h);
      end
      check_stats(1000, 0);
      cfg_thresh_i = 8'd255;
      for (int n = 1; n <= 1000; n++) begin
         h = (lfsr_m[7:0] < cfg_thresh_i);
         lfsr_m = lfsr_step(lfsr_m);
         if (h) hits++;
         send(2'(n), h);
      end
      check_stats(2000, hits);

      // period 0 never hits; period 1 always hits; mask 0 flags without flipping
      do_reset();
      cfg_mode_i = 2'd1; cfg_period_i = 16'd0; cfg_mask_i = 2'b11;
      for (int n = 1; n <= 20; n++) send(2'(n), 1'b0);
      check_stats(20, 0);
      cfg_period_i = 16'd1;
      for (int n = 1; n <= 10; n++) send(2'(n), 1'b1);
      check_stats(30, 20);
      cfg_mask_i = 2'b00;
      for (int n = 1; n <= 5; n++) send(2'(n), 1'b1);
      check_stats(35, 20);

      // burst >= period: no gap at all
      do_reset();
      cfg_mode_i = 2'd2; cfg_period_i = 16'd3; cfg_burst_i = 4'd5; cfg_mask_i = 2'b01;
      for (int n = 1; n <= 12; n++) send(2'(n), 1'b1);
      check_stats(12, 12);

      // burst 0 behaves as 1, then clear with valid wins over the count
      do_reset();
      cfg_mode_i = 2'd2; cfg_period_i = 16'd4; cfg_burst_i = 4'd0; cfg_mask_i = 2'b01;
      for (int n = 1; n <= 12; n++) send(2'(n), (n % 4) == 0);
      check_stats(12, 3);
      send(2'd1, 1'b0);
      clr_stats_i = 1'b1;
      check_stats(0, 0);
      for (int n = 14; n <= 16; n++) send(2'(n), (n % 4) == 0);
      check_stats(3, 1);

      // Reset in the middle of a burst, then restart from phase 0
      do_reset();
      cfg_mode_i = 2'd2; cfg_period_i = 16'd5; cfg_burst_i = 4'd3; cfg_mask_i = 2'b11;
      for (int n = 1; n <= 7; n++) begin
         h = ((n % 5) == 0) || (n > 5 && ((n % 5) == 1 || (n % 5) == 2));
         send(2'(n), h);
      end
      #3;
      do_reset();
      for (int n = 1; n <= 10; n++) begin
         h = ((n % 5) == 0) || (n > 5 && ((n % 5) == 1 || (n % 5) == 2));
         send(2'(n), h);
      end
      check_stats(10, 8);

      repeat (3) @(negedge clk);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
